// File: rtl/pkt_parser_pkg.sv
// Shared types and constants for the pkt_parser_n byte-stream framer.
package pkt_parser_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_PKT_BYTES = 3;
  localparam int DEF_SYNC_BIT  = 3;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [0:0] {
    SEARCH  = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Width needed to hold a byte count of 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pkt_parser_n_if.sv
// Stream-in / packet-out handshake bundle for pkt_parser_n.
interface pkt_parser_n_if #(
  parameter int DATA_W    = 8,
  parameter int PKT_BYTES = 3,
  parameter int CNT_W     = 16
);
  logic                        in_valid;
  logic [DATA_W-1:0]           in_data;
  logic                        out_ready;
  logic                        out_valid;
  logic [DATA_W*PKT_BYTES-1:0] out_bytes;
  logic                        overrun;
  logic                        chk_err;
  logic [CNT_W-1:0]            pkt_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_bytes, overrun, chk_err, pkt_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_bytes, overrun, chk_err, pkt_cnt
  );
endinterface

// File: rtl/pkt_shift_reg.sv
// Packet assembly shift register with a running XOR of the bytes shifted in.
// o_next is the full packet word that results if i_d is shifted in this cycle.
module pkt_shift_reg #(
  parameter int DATA_W    = 8,
  parameter int PKT_BYTES = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_load_first,
  input  logic                        i_shift,
  input  logic [DATA_W-1:0]           i_d,
  output logic [DATA_W*PKT_BYTES-1:0] o_next,
  output logic [DATA_W-1:0]           o_acc
);

  localparam int HOLD_W = DATA_W * (PKT_BYTES - 1);

  // The final byte is never stored: it completes the word straight from i_d,
  // so only the leading PKT_BYTES-1 bytes need holding.
  logic [HOLD_W-1:0] r_hold;
  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
      r_acc  <= '0;
    end else if (i_load_first) begin
      r_hold <= HOLD_W'(i_d);
      r_acc  <= i_d;
    end else if (i_shift) begin
      if (PKT_BYTES > 2) begin
        r_hold <= {r_hold[HOLD_W-DATA_W-1:0], i_d};
      end else begin
        r_hold <= HOLD_W'(i_d);
      end
      r_acc  <= r_acc ^ i_d;
    end
  end

  assign o_next = {r_hold, i_d};
  assign o_acc  = r_acc;

endmodule

// File: rtl/pkt_parser_n.sv
// Parametrised packet framer: hunts for a sync header, collects PKT_BYTES bytes,
// presents the packet with valid/ready. Optional XOR check via PKT_PARSER_CHECKSUM_EN.
//
// state   | meaning
// SEARCH  | waiting for a byte with the sync bit set
// COLLECT | header taken, gathering the remaining bytes
module pkt_parser_n
  import pkt_parser_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PKT_BYTES = DEF_PKT_BYTES,
  parameter int SYNC_BIT  = DEF_SYNC_BIT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  pkt_parser_n_if.slave bus
);

  localparam int CW = cnt_width(PKT_BYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_BYTES - 1);

  state_t                      r_state;
  logic [CW-1:0]               r_cnt;
  logic                        r_out_valid;
  logic [DATA_W*PKT_BYTES-1:0] r_out_bytes;
  logic                        r_overrun;
  logic                        r_chk_err;
  logic [CNT_W-1:0]            r_pkt_cnt;

  logic                        w_hdr;
  logic                        w_shift;
  logic                        w_last;
  logic                        w_chk_ok;
  logic                        w_done;
  logic [DATA_W*PKT_BYTES-1:0] w_next;
  logic [DATA_W-1:0]           w_acc;

  assign w_hdr   = (r_state == SEARCH)  && bus.in_valid && bus.in_data[SYNC_BIT];
  assign w_shift = (r_state == COLLECT) && bus.in_valid;
  assign w_last  = w_shift && (r_cnt == LAST_CNT);

`ifdef PKT_PARSER_CHECKSUM_EN
  assign w_chk_ok = (bus.in_data == w_acc);
`else
  logic w_unused_acc;
  assign w_unused_acc = ^w_acc;
  assign w_chk_ok     = 1'b1;
`endif

  assign w_done = w_last && w_chk_ok;

  pkt_shift_reg #(
    .DATA_W    (DATA_W),
    .PKT_BYTES (PKT_BYTES)
  ) u_shift (
    .i_clk        (clk),
    .i_rst_n      (reset_n),
    .i_load_first (w_hdr),
    .i_shift      (w_shift),
    .i_d          (bus.in_data),
    .o_next       (w_next),
    .o_acc        (w_acc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SEARCH;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_bytes <= '0;
      r_overrun   <= 1'b0;
      r_chk_err   <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      r_overrun <= 1'b0;
      r_chk_err <= 1'b0;

      case (r_state)
        SEARCH: begin
          if (w_hdr) begin
            r_state <= COLLECT;
            r_cnt   <= CW'(1);
          end
        end
        COLLECT: begin
          if (w_last) begin
            r_state <= SEARCH;
            r_cnt   <= '0;
          end else if (w_shift) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= SEARCH;
          r_cnt   <= '0;
        end
      endcase

      // A completion wins over a same-edge consume: the new packet stays valid.
      if (w_done) begin
        r_out_bytes <= w_next;
        r_out_valid <= 1'b1;
        r_pkt_cnt   <= r_pkt_cnt + CNT_W'(1);
        r_overrun   <= r_out_valid && !bus.out_ready;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_last && !w_chk_ok) begin
        r_chk_err <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_bytes = r_out_bytes;
  assign bus.overrun   = r_overrun;
  assign bus.chk_err   = r_chk_err;
  assign bus.pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_pkt_parser_n.sv
// Directed self-checking bench for pkt_parser_n (DATA_W=8, PKT_BYTES=3, SYNC_BIT=3).
module tb_pkt_parser_n;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  pkt_parser_n_if #(.DATA_W(8), .PKT_BYTES(3), .CNT_W(16)) bus ();

  pkt_parser_n #(
    .DATA_W    (8),
    .PKT_BYTES (3),
    .SYNC_BIT  (3),
    .CNT_W     (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input at the falling edge; the next rising edge samples it.
  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_bytes", 64'(bus.out_bytes), 64'd0);
    chk("rst_overrun",   64'(bus.overrun),   64'd0);
    chk("rst_chk_err",   64'(bus.chk_err),   64'd0);
    chk("rst_pkt_cnt",   64'(bus.pkt_cnt),   64'd0);
    reset_n = 1'b1;

    // Basic packet
    step(1'b1, 8'h08);
    step(1'b1, 8'hAA);
    step(1'b1, 8'h55);
    chk("basic_not_early", 64'(bus.out_valid), 64'd0);
    step(1'b0, 8'h00);
    chk("basic_valid", 64'(bus.out_valid), 64'd1);
    chk("basic_bytes", 64'(bus.out_bytes), 64'h08AA55);
    chk("basic_cnt",   64'(bus.pkt_cnt),   64'd1);
    chk("basic_ovr",   64'(bus.overrun),   64'd0);
    step(1'b0, 8'h00);
    chk("basic_one_cycle", 64'(bus.out_valid), 64'd0);

    // Header hunt
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h0C);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b0, 8'h00);
    chk("hunt_valid", 64'(bus.out_valid), 64'd1);
    chk("hunt_bytes", 64'(bus.out_bytes), 64'h0C1122);
    chk("hunt_cnt",   64'(bus.pkt_cnt),   64'd2);

    // Stalled input
    step(1'b1, 8'h08);
    idle(5);
    chk("stall_no_valid", 64'(bus.out_valid), 64'd0);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    chk("stall_not_early", 64'(bus.out_valid), 64'd0);
    step(1'b0, 8'h00);
    chk("stall_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_bytes", 64'(bus.out_bytes), 64'h080102);
    chk("stall_cnt",   64'(bus.pkt_cnt),   64'd3);
    step(1'b0, 8'h00);

    // Back-pressure and overrun
    bus.out_ready = 1'b0;
    step(1'b1, 8'h08);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b0, 8'h00);
    chk("bp1_valid", 64'(bus.out_valid), 64'd1);
    chk("bp1_bytes", 64'(bus.out_bytes), 64'h080102);
    chk("bp1_ovr",   64'(bus.overrun),   64'd0);
    chk("bp1_cnt",   64'(bus.pkt_cnt),   64'd4);
    step(1'b1, 8'h09);
    step(1'b1, 8'h03);
    step(1'b1, 8'h04);
    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_hold_bytes", 64'(bus.out_bytes), 64'h080102);
    step(1'b0, 8'h00);
    chk("bp2_valid", 64'(bus.out_valid), 64'd1);
    chk("bp2_bytes", 64'(bus.out_bytes), 64'h090304);
    chk("bp2_ovr",   64'(bus.overrun),   64'd1);
    chk("bp2_cnt",   64'(bus.pkt_cnt),   64'd5);
    step(1'b0, 8'h00);
    chk("bp_ovr_pulse", 64'(bus.overrun),   64'd0);
    chk("bp_still_val", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_consumed", 64'(bus.out_valid), 64'd0);
    chk("bp_bytes_held", 64'(bus.out_bytes), 64'h090304);
    bus.out_ready = 1'b1;

    // Reset mid-packet, asserted between clock edges
    step(1'b1, 8'h08);
    step(1'b1, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    chk("amid_valid", 64'(bus.out_valid), 64'd0);
    chk("amid_bytes", 64'(bus.out_bytes), 64'd0);
    chk("amid_cnt",   64'(bus.pkt_cnt),   64'd0);
    chk("amid_ovr",   64'(bus.overrun),   64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'h77);
    step(1'b1, 8'h88);
    idle(3);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_cnt",   64'(bus.pkt_cnt),   64'd0);
    chk("post_rst_bytes", 64'(bus.out_bytes), 64'd0);
    do_reset();

    // Checksum scenario, held under back-pressure so out_valid is observable
    bus.out_ready = 1'b0;
    step(1'b1, 8'h08);
    step(1'b1, 8'h01);
    step(1'b1, 8'h09);
    step(1'b0, 8'h00);
    chk("cks_ok_valid", 64'(bus.out_valid), 64'd1);
    chk("cks_ok_bytes", 64'(bus.out_bytes), 64'h080109);
    chk("cks_ok_cnt",   64'(bus.pkt_cnt),   64'd1);
    chk("cks_ok_err",   64'(bus.chk_err),   64'd0);
    step(1'b1, 8'h08);
    step(1'b1, 8'h01);
    step(1'b1, 8'h00);
    step(1'b0, 8'h00);
`ifdef PKT_PARSER_CHECKSUM_EN
    chk("cks_bad_err",   64'(bus.chk_err),   64'd1);
    chk("cks_bad_valid", 64'(bus.out_valid), 64'd1);
    chk("cks_bad_bytes", 64'(bus.out_bytes), 64'h080109);
    chk("cks_bad_cnt",   64'(bus.pkt_cnt),   64'd1);
    chk("cks_bad_ovr",   64'(bus.overrun),   64'd0);
`else
    chk("nocks_err",   64'(bus.chk_err),   64'd0);
    chk("nocks_valid", 64'(bus.out_valid), 64'd1);
    chk("nocks_bytes", 64'(bus.out_bytes), 64'h080100);
    chk("nocks_cnt",   64'(bus.pkt_cnt),   64'd2);
    chk("nocks_ovr",   64'(bus.overrun),   64'd1);
`endif
    step(1'b0, 8'h00);
    chk("err_pulse_end", 64'(bus.chk_err), 64'd0);
    bus.out_ready = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
